// File: rtl/neo_audio_mc.sv
`timescale 1ns/1ps
// neo_audio_mc -- multi-lane I2S transmitter with a Wishbone slave port.
//
// Samples written to the DATA register are queued in a FIFO. A prefetch FSM
// moves one complete frame (2*LANES samples) from the FIFO into a staging
// buffer. At each frame start the staging buffer is copied into per-lane
// shift registers, which are serialised in standard I2S format. All lanes
// share MCLK/SCLK/LRCLK.
//
// Ports
//   clk        system clock (single domain)
//   arst       asynchronous reset, active high
//   wb_adr_i   Wishbone address; block decoded on [31:4], register on [3:2]
//   wb_dat_i   write data
//   wb_dat_o   read data, valid while wb_ack_o is high (0 otherwise)
//   wb_we_i    write enable
//   wb_sel_i   byte selects (unused, full-word access only)
//   wb_stb_i   strobe
//   wb_ack_o   acknowledge, one cycle
//   irq_o      level interrupt: EN & (level <= THRESH | UNDERRUN | OVERFLOW)
//   i2s_mclk   master clock
//   i2s_sclk   bit clock
//   i2s_lrclk  word select, 0 = left
//   i2s_sdata  serial data, lane k carries channels 2k (L) and 2k+1 (R)
//
// Register map (wb_adr_i[3:2])
//   0 CTRL   rw  [0] EN, [1] CLR (write 1 clears sticky flags, reads 0), [15:8] THRESH
//   1 STATUS ro  [0] UNDERRUN, [1] OVERFLOW, [2] FULL, [3] EMPTY, [31:16] level
//   2 DATA   wo  push wb_dat_i[SAMPLE_W-1:0]
//   3 reserved
//
// The debug-visible FSM state is state_q (IDLE/LOAD/WAIT).
module neo_audio_mc #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          LANES      = 2,
  parameter int          SAMPLE_W   = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter int          SCLK_HALF  = 4,
  parameter int          MCLK_HALF  = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             irq_o,
  output logic             i2s_mclk,
  output logic             i2s_sclk,
  output logic             i2s_lrclk,
  output logic [LANES-1:0] i2s_sdata
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int NCH = 2 * LANES;
  localparam int CW  = $clog2(NCH);
  localparam int FW  = 2 * SAMPLE_W;
  localparam int BW  = $clog2(FW);
  localparam int SCW = $clog2(SCLK_HALF);
  localparam int MCW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // ---------------------------------------------------------------------
  // Bus handshake: a strobe to this block is acknowledged exactly one clock
  // after it is first seen, for one cycle. The register side effect and the
  // read data are committed on the same edge that raises wb_ack_o. While the
  // strobe stays high after its ack (held_q) no further ack is produced, so
  // each strobe performs exactly one access.
  // ---------------------------------------------------------------------
  logic        hit;
  logic        ack_q, ack_d;
  logic        held_q, held_d;
  logic [31:0] dat_q;
  logic [31:0] rdata;
  logic        wr_ctrl, push_req;

  assign hit      = (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign ack_d    = wb_stb_i & hit & ~ack_q & ~held_q;
  assign held_d   = wb_stb_i & (held_q | ack_q);
  assign wr_ctrl  = ack_d & wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign push_req = ack_d & wb_we_i & (wb_adr_i[3:2] == 2'd2);

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  // Control / status
  logic          en_q;
  logic [7:0]    thresh_q;
  logic          unr_q, unr_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          clr;
  logic          set_unr;

  // FIFO
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                full, empty, push, pop;
  logic [SAMPLE_W-1:0] fifo_rd;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign push    = push_req & ~full;
  assign fifo_rd = mem[rd_ptr_q];
  assign clr     = wr_ctrl & wb_dat_i[1];

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      2'd0:    rdata = {16'd0, thresh_q, 7'd0, en_q};
      2'd1:    rdata = {16'(level_q), 12'd0, empty, full, ovf_q, unr_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // A new event in the same cycle as CLR wins, so it is never lost.
  assign unr_d = (unr_q & ~clr) | set_unr;
  assign ovf_d = (ovf_q & ~clr) | (push_req & full);
  assign irq_d = en_q & ((32'(level_q) <= 32'(thresh_q)) | unr_q | ovf_q);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ack_q    <= 1'b0;
      held_q   <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      thresh_q <= '0;
      unr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      held_q <= held_d;
      dat_q  <= (ack_d && !wb_we_i) ? rdata : '0;
      if (wr_ctrl) begin
        en_q     <= wb_dat_i[0];
        thresh_q <= wb_dat_i[15:8];
      end
      unr_q   <= unr_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage has no reset; level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wb_dat_i[SAMPLE_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Clock generation and serialiser. Everything here is held at zero while
  // EN is low. A "slot" is one SCLK period starting with its low phase;
  // slot 0 of a frame begins at the LRCLK falling edge.
  // ---------------------------------------------------------------------
  logic             mclk_q, sclk_q, lr_q;
  logic [MCW-1:0]   mclk_cnt_q;
  logic [SCW-1:0]   sclk_cnt_q;
  logic [BW-1:0]    slot_q, slot_nx;
  logic [LANES-1:0] sdata_q;
  logic [FW-1:0]    shift_q [LANES];
  logic             fall_evt, frame_start;

  logic [SAMPLE_W-1:0] stage_q [NCH];
  logic [SAMPLE_W-1:0] stage_d [NCH];

  assign fall_evt    = en_q & sclk_q & (sclk_cnt_q == SCW'(SCLK_HALF - 1));
  assign frame_start = fall_evt & (slot_q == BW'(FW - 1));
  assign slot_nx     = frame_start ? '0 : slot_q + BW'(1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mclk_q     <= 1'b0;
      mclk_cnt_q <= '0;
      sclk_q     <= 1'b0;
      sclk_cnt_q <= '0;
      slot_q     <= '0;
      lr_q       <= 1'b0;
      sdata_q    <= '0;
      for (int k = 0; k < LANES; k++) shift_q[k] <= '0;
    end else if (!en_q) begin
      mclk_q     <= 1'b0;
      mclk_cnt_q <= '0;
      sclk_q     <= 1'b0;
      sclk_cnt_q <= '0;
      slot_q     <= '0;
      lr_q       <= 1'b0;
      sdata_q    <= '0;
      for (int k = 0; k < LANES; k++) shift_q[k] <= '0;
    end else begin
      if (mclk_cnt_q == MCW'(MCLK_HALF - 1)) begin
        mclk_cnt_q <= '0;
        mclk_q     <= ~mclk_q;
      end else begin
        mclk_cnt_q <= mclk_cnt_q + MCW'(1);
      end
      if (sclk_cnt_q == SCW'(SCLK_HALF - 1)) begin
        sclk_cnt_q <= '0;
        sclk_q     <= ~sclk_q;
      end else begin
        sclk_cnt_q <= sclk_cnt_q + SCW'(1);
      end
      if (fall_evt) begin
        slot_q <= slot_nx;
        lr_q   <= (slot_nx >= BW'(SAMPLE_W));
        // The bit leaving at slot 0 is the right-channel LSB of the frame
        // just finished, so the reload happens on that same edge and the
        // new left MSB appears one slot later.
        for (int k = 0; k < LANES; k++) begin
          sdata_q[k] <= shift_q[k][FW-1];
          if (frame_start) shift_q[k] <= {stage_q[2*k], stage_q[2*k+1]};
          else             shift_q[k] <= {shift_q[k][FW-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefetch FSM: on EN rise and on every frame start, either pop a whole
  // frame into staging (LOAD) or, if not enough is queued, stage silence
  // and flag UNDERRUN without touching the FIFO.
  // ---------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic          trigger;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    stage_d    = stage_q;
    pop        = 1'b0;
    set_unr    = 1'b0;
    trigger    = 1'b0;
    case (state_q)
      S_IDLE: trigger = en_q;
      S_LOAD: begin
        pop                 = 1'b1;
        stage_d[load_cnt_q] = fifo_rd;
        if (load_cnt_q == CW'(NCH - 1)) state_d = S_WAIT;
        else                            load_cnt_d = load_cnt_q + CW'(1);
      end
      S_WAIT: trigger = frame_start;
      default: state_d = S_IDLE;
    endcase
    if (trigger) begin
      load_cnt_d = '0;
      if (level_q >= LW'(NCH)) begin
        state_d = S_LOAD;
      end else begin
        state_d = S_WAIT;
        set_unr = 1'b1;
        for (int c = 0; c < NCH; c++) stage_d[c] = '0;
      end
    end
    if (!en_q) begin
      state_d    = S_IDLE;
      load_cnt_d = '0;
      pop        = 1'b0;
      set_unr    = 1'b0;
      for (int c = 0; c < NCH; c++) stage_d[c] = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      for (int c = 0; c < NCH; c++) stage_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      stage_q    <= stage_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign irq_o     = irq_q;
  assign i2s_mclk  = mclk_q;
  assign i2s_sclk  = sclk_q;
  assign i2s_lrclk = lr_q;
  assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_neo_audio_mc.sv
`timescale 1ns/1ps
// Directed bench for neo_audio_mc (LANES=2, SAMPLE_W=16, FIFO_DEPTH=64,
// SCLK_HALF=4, MCLK_HALF=1). Serial output is decoded as a standard I2S
// receiver would (sampling on SCLK rising edges) and compared against the
// expected word queue.
module tb_neo_audio_mc;

  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam int          LANES = 2;
  localparam int          W     = 16;
  localparam int          DEPTH = 64;

  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DATA   = BASE + 32'h8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [31:0]      wb_adr, wb_dat_w, wb_dat_r;
  logic             wb_we, wb_stb, wb_ack;
  logic [3:0]       wb_sel;
  logic             irq, mclk, sclk, lrclk;
  logic [LANES-1:0] sdata;

  neo_audio_mc #(
    .BASE_ADDR (BASE),
    .LANES     (LANES),
    .SAMPLE_W  (W),
    .FIFO_DEPTH(DEPTH),
    .SCLK_HALF (4),
    .MCLK_HALF (1)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_w),
    .wb_dat_o (wb_dat_r),
    .wb_we_i  (wb_we),
    .wb_sel_i (wb_sel),
    .wb_stb_i (wb_stb),
    .wb_ack_o (wb_ack),
    .irq_o    (irq),
    .i2s_mclk (mclk),
    .i2s_sclk (sclk),
    .i2s_lrclk(lrclk),
    .i2s_sdata(sdata)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];   // expected words, lane0 then lane1 per word slot

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    @(negedge clk);
    wb_adr = addr; wb_we = 1'b0; wb_stb = 1'b1;
    lat = 0; data = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin lat = i; data = wb_dat_r; break; end
    end
    @(negedge clk);
    wb_stb = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    int lat;
    @(negedge clk);
    wb_adr = addr; wb_dat_w = data; wb_we = 1'b1; wb_stb = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin lat = i; break; end
    end
    @(negedge clk);
    wb_stb = 1'b0; wb_we = 1'b0;
    check("write_ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    wb_read(addr, d, lat);
    check({tag, "_ack"}, 32'(lat), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic wait_lr_high(output logic found);
    found = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (lrclk && sclk) begin found = 1'b1; break; end
    end
  endtask

  // Decode nwords I2S words on both lanes. Must be called right after the
  // EN-setting write returns (before the first SCLK rise).
  task automatic capture(input int nwords);
    logic [W-1:0] acc0, acc1, e0, e1;
    logic         prev_lr, prev_sclk, m0;
    int           got, rises, first_rise;
    acc0 = '0; acc1 = '0; prev_lr = 1'b0; prev_sclk = 1'b0; m0 = 1'b0;
    got = 0; rises = 0; first_rise = 0;
    for (int cyc = 0; cyc < nwords * W * 8 + 64; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) m0 = mclk;
      if (cyc == 1) check("mclk_toggle", 32'({m0, mclk}), 32'b10);
      if (sclk && !prev_sclk) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        if (rises == 2) check("sclk_period", 32'(cyc - first_rise), 32'd8);
        if (lrclk != prev_lr) begin
          e0 = exp_q.pop_front();
          e1 = exp_q.pop_front();
          check($sformatf("lane0_word%0d", got), 32'({acc0[W-2:0], sdata[0]}), 32'(e0));
          check($sformatf("lane1_word%0d", got), 32'({acc1[W-2:0], sdata[1]}), 32'(e1));
          got++;
          acc0 = '0; acc1 = '0;
        end else begin
          acc0 = {acc0[W-2:0], sdata[0]};
          acc1 = {acc1[W-2:0], sdata[1]};
        end
        prev_lr = lrclk;
      end
      prev_sclk = sclk;
      if (got == nwords) break;
    end
    check("capture_words", 32'(got), 32'(nwords));
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  int          lat;
  logic        a1, a2, a3, found;

  initial begin
    arst = 1'b1; wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_sel = 4'hF;
    #1;
    check("reset_outputs", 32'({mclk, sclk, lrclk, sdata, irq, wb_ack}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b0;

    // Reset state and bus behaviour
    read_check("status_after_reset", A_STATUS, 32'h0000_0008);
    read_check("ctrl_after_reset", A_CTRL, 32'h0000_0000);
    wb_read(BASE + 32'h10, rd, lat);
    check("no_ack_out_of_range", 32'(lat), 32'd0);
    @(negedge clk); wb_adr = A_STATUS; wb_we = 1'b0; wb_stb = 1'b1;
    @(posedge clk); #1; a1 = wb_ack;
    @(posedge clk); #1; a2 = wb_ack;
    @(posedge clk); #1; a3 = wb_ack;
    @(negedge clk); wb_stb = 1'b0;
    check("held_stb_single_ack", 32'({a1, a2, a3}), 32'b100);

    // Two frames of samples across both lanes
    wb_write(A_DATA, 32'hDEAD_A5A5);  // upper bits ignored
    wb_write(A_DATA, 32'h0000_0F0F);
    wb_write(A_DATA, 32'h0000_3C3C);
    wb_write(A_DATA, 32'h0000_C3C3);
    wb_write(A_DATA, 32'h0000_0001);
    wb_write(A_DATA, 32'h0000_0002);
    wb_write(A_DATA, 32'h0000_0003);
    wb_write(A_DATA, 32'h0000_0004);
    read_check("status_level8", A_STATUS, 32'h0008_0000);
    exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'hA5A5, 16'h3C3C, 16'h0F0F, 16'hC3C3,
              16'h0001, 16'h0003, 16'h0002, 16'h0004};
    wb_write(A_CTRL, 32'h0000_0001);
    capture(6);
    read_check("status_drained_underrun", A_STATUS, 32'h0000_0009);
    check("irq_when_enabled_empty", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0000_0000);
    wb_write(A_CTRL, 32'h0000_0002);
    read_check("status_after_clr", A_STATUS, 32'h0000_0008);

    // Underrun: one queued sample is not enough for a frame
    wb_write(A_DATA, 32'h0000_7777);
    wb_write(A_CTRL, 32'h0000_0001);
    repeat (4) @(posedge clk);
    read_check("status_underrun", A_STATUS, 32'h0001_0001);
    check("irq_underrun", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0000_0003);
    read_check("status_underrun_cleared", A_STATUS, 32'h0001_0000);
    read_check("ctrl_clr_reads_0", A_CTRL, 32'h0000_0001);

    // EN cleared mid-frame while LRCLK is high
    wait_lr_high(found);
    check("lrclk_high_seen", 32'(found), 32'd1);
    wb_write(A_CTRL, 32'h0000_0000);
    @(posedge clk); #1;
    check("en_clear_outputs", 32'({mclk, sclk, lrclk, sdata}), 32'd0);
    read_check("fifo_survives_disable", A_STATUS, 32'h0001_0000);

    // Asynchronous reset mid-frame
    wb_write(A_CTRL, 32'h0000_0001);
    wait_lr_high(found);
    check("lrclk_high_seen2", 32'(found), 32'd1);
    #2 arst = 1'b1;
    #1;
    check("arst_outputs", 32'({mclk, sclk, lrclk, sdata, irq}), 32'd0);
    @(negedge clk); arst = 1'b0;
    read_check("status_after_arst", A_STATUS, 32'h0000_0008);
    read_check("ctrl_after_arst", A_CTRL, 32'h0000_0000);

    // Threshold boundary: 12 queued, one frame prefetched -> level 8
    for (int i = 0; i < 12; i++) wb_write(A_DATA, 32'h200 + 32'(i));
    wb_write(A_CTRL, 32'h0000_0701);
    repeat (10) @(posedge clk); #1;
    read_check("status_level8_en", A_STATUS, 32'h0008_0000);
    check("irq_level_above_thresh", 32'(irq), 32'd0);
    wb_write(A_CTRL, 32'h0000_0801);
    repeat (2) @(posedge clk); #1;
    check("irq_level_eq_thresh", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0000_0000);

    // Overflow: DEPTH+1 pushes with EN=0
    @(negedge clk); arst = 1'b1;
    @(negedge clk); arst = 1'b0;
    for (int i = 0; i <= DEPTH; i++) wb_write(A_DATA, 32'h100 + 32'(i));
    read_check("status_overflow", A_STATUS, 32'h0040_0006);
    check("irq_disabled", 32'(irq), 32'd0);
    wb_write(A_CTRL, 32'h0000_0002);
    read_check("status_ovf_cleared", A_STATUS, 32'h0040_0004);
    // Oldest samples must still be at the head after the dropped push
    exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'h0100, 16'h0102, 16'h0101, 16'h0103};
    wb_write(A_CTRL, 32'h0000_0001);
    capture(4);
    wb_write(A_CTRL, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
